kme_apb_csr_responder: RTL
==========================

# kme_apb_csr_responder

APB3 completer that terminates register-bus transactions driven by the KME config engine and exposes a small control/status register bank to core logic. It sits between the APB port of a KME sub-block and its datapath. It decodes word-aligned addresses, inserts a programmable number of wait states, returns slave errors on illegal accesses, and maintains one sticky write-1-to-clear status register.

## Interface
- ADDR_WIDTH, 16, width of apb_paddr
- DATA_WIDTH, 32, width of APB data and of every register
- NUM_REGS, 8, register count, minimum 3; decoded range is 0 .. 4*NUM_REGS-1
- WAIT_CYCLES, 1, extra access-phase cycles before pready, range 0..15
- ID_VALUE, 32'h4B4D_0001, constant returned by register 0

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- apb_paddr  in  ADDR_WIDTH  byte address
- apb_psel  in  1  select
- apb_penable  in  1  access phase
- apb_pwrite  in  1  1 = write
- apb_pwdata  in  DATA_WIDTH  write data
- apb_prdata  out  DATA_WIDTH  read data, valid only while apb_pready = 1
- apb_pready  out  1  transfer completion, registered
- apb_pslverr  out  1  error qualifier, valid only while apb_pready = 1
- status_set  in  DATA_WIDTH  per-bit set pulses into sticky register 1
- cfg_regs  out  NUM_REGS*DATA_WIDTH  flat register image; slice i = register i
- cfg_wr_pulse  out  1  one-cycle pulse when a control register (index ≥ 2) is written
- cfg_wr_index  out  clog2(NUM_REGS)  index of the register written; held until the next write

## Operation
- Register map by word index (paddr[ADDR_WIDTH-1:2]):
  - 0: read-only ID_VALUE. Writes to index 0 return pslverr with no effect.
  - 1: sticky status, write-1-to-clear.
  - 2..NUM_REGS-1: read/write control registers.
- Error conditions, each producing pslverr = 1 with no state change:
  - paddr[1:0] != 0;
  - word index ≥ NUM_REGS;
  - write to index 0.
  - Reads on an error return prdata = 0.
- State machine states and transitions:
  - IDLE: go to SETUP when psel=1 and penable=0. Start the wait counter at WAIT_CYCLES.
  - SETUP: penable=1 goes to WAIT. psel=0 goes to IDLE. psel=1 with penable=0 stays in SETUP and re-samples the address.
  - WAIT: the counter decrements each cycle. At 0 go to RESP. psel=0 aborts to IDLE with no commit.
  - RESP: pready=1 for exactly one cycle, then return to IDLE.
- The address, pwrite and pwdata sampled in SETUP are the values used. Changes during WAIT are ignored.
- Write commit occurs on the clk edge that ends the RESP cycle. cfg_wr_pulse is high the following cycle for control writes only.
- Sticky register 1: next = (cur & ~clr) | status_set.
  - clr = pwdata only on a legal commit to index 1; otherwise clr = 0.
  - If set and clear hit the same bit in the same cycle, set wins.
- Reset values:
  - state IDLE;
  - registers 1..NUM_REGS-1 = 0;
  - apb_prdata = 0, apb_pready = 0, apb_pslverr = 0;
  - cfg_wr_pulse = 0, cfg_wr_index = 0.
- rst asserted mid-transfer drops the transfer: no commit, no pready, state IDLE on the next cycle.
- The status_set capture is suppressed while rst = 1.

## Timing
- Let T0 be the setup cycle. penable=1 at T1. pready=1 in cycle T1+1+WAIT_CYCLES.
- Minimum transfer is 3 cycles (WAIT_CYCLES = 0).
- prdata and pslverr are registered and change only when entering RESP. Both are 0 outside RESP.
- Read data is the register value at the end of the WAIT phase. A status_set in the RESP cycle is not reflected in prdata.
- Back-to-back transfers: a new SETUP can be accepted in the cycle directly after RESP, so there is no idle gap.
- cfg_regs updates one cycle after the RESP cycle, at the same edge as cfg_wr_pulse rising.

## Test plan
- Reset, then read address 0x0 with WAIT_CYCLES = 1 → pready in the 4th cycle, prdata = 0x4B4D0001, pslverr = 0.
- Write 0xDEADBEEF to 0x8, then read 0x8 → cfg_wr_pulse for one cycle with cfg_wr_index = 2; cfg_regs slice 2 = 0xDEADBEEF; read returns 0xDEADBEEF.
- Error cases:
  - write 0x1 to 0x0 → pslverr = 1, register 0 unchanged;
  - write 0x1234 to 0x6 (misaligned) → pslverr = 1;
  - write 0x1234 to 0x20 (NUM_REGS = 8) → pslverr = 1, no cfg_wr_pulse;
  - read from 0x20 → prdata = 0, pslverr = 1.
- Sticky register:
  - pulse status_set = 0x5;
  - write 0x1 to 0x4 in the same cycle that status_set = 0x1 → a read of 0x4 returns 0x5 (set wins);
  - write 0x5 again → a read returns 0x0.
- Abort and reset: drop psel during WAIT with WAIT_CYCLES = 3 → no pready, no write. Assert rst during WAIT of a write to 0xC → the register stays 0, pready never rises, and the next transfer completes normally.
- Back-to-back: run two writes to 0x8 and 0xC separated by no idle cycle → both commit; two cfg_wr_pulse with indices 2 then 3.

Source files
------------

// File: rtl/kme_apb_csr_responder.sv
// kme_apb_csr_responder
// APB3 completer for a KME sub-block. It decodes word-aligned addresses,
// inserts WAIT_CYCLES wait states, flags illegal accesses with pslverr and
// holds a small register bank:
//   index 0               read-only ID_VALUE
//   index 1               sticky status, write-1-to-clear, set by status_set
//   index 2..NUM_REGS-1   read/write control registers
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   apb_paddr/psel/penable/
//   apb_pwrite/apb_pwdata        APB request from the config engine
//   apb_prdata/pready/pslverr    registered APB response, non-zero only in RESP
//   status_set                   per-bit set pulses into the sticky register
//   cfg_regs                     flat image, slice i = register i
//   cfg_wr_pulse/cfg_wr_index    one-cycle strobe and index of a control write
module kme_apb_csr_responder #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'h4B4D_0001
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          apb_paddr,
  input  logic                           apb_psel,
  input  logic                           apb_penable,
  input  logic                           apb_pwrite,
  input  logic [DATA_WIDTH-1:0]          apb_pwdata,
  output logic [DATA_WIDTH-1:0]          apb_prdata,
  output logic                           apb_pready,
  output logic                           apb_pslverr,
  input  logic [DATA_WIDTH-1:0]          status_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
  output logic                           cfg_wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]    cfg_wr_index
);

  localparam int         IDX_W     = $clog2(NUM_REGS);
  localparam int         WIDX_W    = ADDR_WIDTH - 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [3:0]              wait_cnt_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    write_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_WIDTH-1:0]   status_r;
  logic [DATA_WIDTH-1:0]   ctrl_r [2:NUM_REGS-1];

  logic [WIDX_W-1:0]       word_idx_s;
  logic [IDX_W-1:0]        reg_idx_s;
  logic                    in_range_s;
  logic                    err_s;
  logic                    commit_s;
  logic                    ctrl_commit_s;
  logic [DATA_WIDTH-1:0]   rdata_s;
  logic [DATA_WIDTH-1:0]   clr_s;
  logic [DATA_WIDTH-1:0]   regs_s [NUM_REGS];

  // Decode works only on the request captured in SETUP, so address or data
  // changes during WAIT cannot affect the response or the commit.
  assign word_idx_s    = addr_r[ADDR_WIDTH-1:2];
  assign reg_idx_s     = word_idx_s[IDX_W-1:0];
  assign in_range_s    = (word_idx_s < WIDX_W'(NUM_REGS));
  assign err_s         = (addr_r[1:0] != 2'b00) || !in_range_s ||
                         (write_r && (word_idx_s == {WIDX_W{1'b0}}));
  assign commit_s      = (state_r == ST_RESP) && write_r && !err_s;
  assign ctrl_commit_s = commit_s && (word_idx_s >= WIDX_W'(2));

  // Assemble the full register view (ID, sticky status, control registers).
  always_comb begin
    regs_s[0] = ID_VALUE;
    regs_s[1] = status_r;
    for (int i = 2; i < NUM_REGS; i++) begin
      regs_s[i] = ctrl_r[i];
    end
  end

  // Read mux; illegal accesses read back as zero.
  always_comb begin
    if (err_s) begin
      rdata_s = {DATA_WIDTH{1'b0}};
    end else begin
      rdata_s = regs_s[reg_idx_s];
    end
  end

  // Clear mask for the sticky register, non-zero only on a legal commit to index 1.
  always_comb begin
    if (commit_s && (word_idx_s == WIDX_W'(1))) begin
      clr_s = wdata_r;
    end else begin
      clr_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Flatten the register view onto the cfg_regs output.
  always_comb begin
    cfg_regs = {(NUM_REGS*DATA_WIDTH){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      cfg_regs[i*DATA_WIDTH +: DATA_WIDTH] = regs_s[i];
    end
  end

  // APB transfer FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 4'd0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      write_r     <= 1'b0;
      wdata_r     <= {DATA_WIDTH{1'b0}};
      apb_prdata  <= {DATA_WIDTH{1'b0}};
      apb_pready  <= 1'b0;
      apb_pslverr <= 1'b0;
    end else begin
      // Response outputs are only non-zero for the single RESP cycle.
      apb_prdata  <= {DATA_WIDTH{1'b0}};
      apb_pready  <= 1'b0;
      apb_pslverr <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (apb_psel && !apb_penable) begin
            state_r    <= ST_SETUP;
            wait_cnt_r <= WAIT_INIT;
            addr_r     <= apb_paddr;
            write_r    <= apb_pwrite;
            wdata_r    <= apb_pwdata;
          end
        end
        ST_SETUP: begin
          if (!apb_psel) begin
            state_r <= ST_IDLE;
          end else if (!apb_penable) begin
            // A repeated setup phase replaces the captured request.
            addr_r  <= apb_paddr;
            write_r <= apb_pwrite;
            wdata_r <= apb_pwdata;
          end else if (wait_cnt_r == 4'd0) begin
            state_r     <= ST_RESP;
            apb_pready  <= 1'b1;
            apb_pslverr <= err_s;
            apb_prdata  <= rdata_s;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!apb_psel) begin
            state_r <= ST_IDLE;
          end else if (wait_cnt_r <= 4'd1) begin
            // Read data is taken from the registers as the wait phase ends.
            state_r     <= ST_RESP;
            wait_cnt_r  <= 4'd0;
            apb_pready  <= 1'b1;
            apb_pslverr <= err_s;
            apb_prdata  <= rdata_s;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Register bank: sticky status, control registers and the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r     <= {DATA_WIDTH{1'b0}};
      cfg_wr_pulse <= 1'b0;
      cfg_wr_index <= {IDX_W{1'b0}};
      for (int i = 2; i < NUM_REGS; i++) begin
        ctrl_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      // Set is OR-ed in after the clear, so a simultaneous set wins.
      status_r     <= (status_r & ~clr_s) | status_set;
      cfg_wr_pulse <= ctrl_commit_s;
      if (ctrl_commit_s) begin
        cfg_wr_index <= reg_idx_s;
      end
      for (int i = 2; i < NUM_REGS; i++) begin
        if (ctrl_commit_s && (reg_idx_s == IDX_W'(i))) begin
          ctrl_r[i] <= wdata_r;
        end
      end
    end
  end

endmodule
